// File: rtl/pipe_sequencer.sv
// Pipeline hazard / halt sequencer: load-use stalls, branch flushes, and a
// three-cycle drain into HALTED that is left on a resume request.
module pipe_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_halt,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        ex_branch_taken,
   input  logic        resume,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

   state_t      r_state, w_next;
   logic [1:0]  r_drain_cnt, w_drain_nxt;
   logic        r_halted;
   logic [15:0] r_stall_cnt;
   logic        w_load_use;
   logic        w_stall_inc;

   assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   always_comb begin
      w_next      = r_state;
      w_drain_nxt = r_drain_cnt;
      w_stall_inc = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      // While in reset the outputs read as a free-running RUN pipeline.
      if (rst_n) begin
         unique case (r_state)
            RUN: begin
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (w_load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_flush  = 1'b1;
                  w_stall_inc = 1'b1;
               end else if (id_halt) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_flush  = 1'b1;
                  w_next      = DRAIN;
                  w_drain_nxt = 2'd3;
               end
            end
            DRAIN: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_flush  = 1'b1;
               w_drain_nxt = r_drain_cnt - 2'd1;
               if (r_drain_cnt == 2'd1) w_next = HALTED;
            end
            HALTED: begin
               idex_flush = 1'b1;
               if (resume) begin
                  w_next = RUN;
               end else begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
               end
            end
            default: w_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_drain_cnt <= 2'd0;
         r_halted    <= 1'b0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state     <= w_next;
         r_drain_cnt <= w_drain_nxt;
         r_halted    <= (w_next == HALTED);
         if (w_stall_inc && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign halted    = r_halted;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios with literal expectations, then
// randomized traffic and a long saturation run, all compared against a model.
module tb_pipe_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_halt = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic        ex_memread = 1'b0, ex_branch_taken = 1'b0, resume = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, halted;
   logic [15:0] stall_cnt;

   int n_chk = 0;
   int n_pass = 0;

   pipe_sequencer dut (
      .clk(clk), .rst_n(rst_n), .id_halt(id_halt), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .resume(resume), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Model: drain cycles still to go, a halted flag and a plain stall counter.
   int m_drain_left = 0;
   bit m_halted = 0;
   int m_stalls = 0;

   function automatic bit lu();
      return ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
   endfunction

   // {pc_write, ifid_write, ifid_flush, idex_flush}
   function automatic logic [3:0] exp_outs();
      if (!rst_n)               return 4'b1100;
      if (m_halted)             return resume ? 4'b1101 : 4'b0001;
      if (m_drain_left > 0)     return 4'b0001;
      if (ex_branch_taken)      return 4'b1111;
      if (lu() || id_halt)      return 4'b0001;
      return 4'b1100;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_drain_left <= 0;
         m_halted     <= 0;
         m_stalls     <= 0;
      end else if (m_halted) begin
         if (resume) m_halted <= 0;
      end else if (m_drain_left > 0) begin
         m_drain_left <= m_drain_left - 1;
         if (m_drain_left == 1) m_halted <= 1;
      end else if (!ex_branch_taken) begin
         if (lu()) m_stalls <= (m_stalls < 65535) ? m_stalls + 1 : 65535;
         else if (id_halt) m_drain_left <= 3;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      check("outs", {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp_outs()});
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("stall_cnt", {16'd0, stall_cnt}, m_stalls[31:0]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_halt = 0; ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      ex_branch_taken = 0; resume = 0;
   endtask

   function automatic logic [31:0] outs4();
      return {28'd0, pc_write, ifid_write, ifid_flush, idex_flush};
   endfunction

   initial begin
      idle();
      ex_branch_taken = 1;
      #2;
      check("rst_outs", outs4(), 32'hC);
      check("rst_stall", {16'd0, stall_cnt}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1; idle();
      step();

      // load-use stall
      ex_memread = 1; ex_rd = 5; id_rs2 = 5;
      #1 check("lu_outs", outs4(), 32'h1);
      check("lu_stall0", {16'd0, stall_cnt}, 32'd0);
      step();
      check("lu_stall1", {16'd0, stall_cnt}, 32'd1);
      ex_rd = 0;
      #1 check("rd0_outs", outs4(), 32'hC);
      step();
      check("rd0_stall", {16'd0, stall_cnt}, 32'd1);

      // branch beats load-use and halt
      ex_rd = 5; ex_branch_taken = 1; id_halt = 1;
      #1 check("br_outs", outs4(), 32'hF);
      step();
      check("br_stall", {16'd0, stall_cnt}, 32'd1);
      idle();
      #1 check("br_run", outs4(), 32'hC);

      // halt: detect cycle then 3 drains, halted on edge 4
      id_halt = 1;
      #1 check("halt_det", outs4(), 32'h1);
      step(); idle();
      check("drain1_h", {31'd0, halted}, 32'd0);
      step();
      ex_branch_taken = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3;
      #1 check("drain_br", outs4(), 32'h1);
      step(); idle();
      check("drain3_h", {31'd0, halted}, 32'd0);
      step();
      check("halted4", {31'd0, halted}, 32'd1);
      check("halt_stall", {16'd0, stall_cnt}, 32'd1);

      // resume
      resume = 1;
      #1 check("resume_outs", outs4(), 32'hD);
      step(); resume = 0;
      check("resumed_h", {31'd0, halted}, 32'd0);
      #1 check("resumed_outs", outs4(), 32'hC);

      // reset in second drain cycle
      id_halt = 1;
      step(); idle();
      step();
      ex_branch_taken = 1;
      rst_n = 0;
      #1 check("mid_rst_pc", {31'd0, pc_write}, 32'd1);
      check("mid_rst_outs", outs4(), 32'hC);
      check("mid_rst_h", {31'd0, halted}, 32'd0);
      check("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
      @(negedge clk); rst_n = 1; idle();
      step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         id_halt         = ($urandom_range(0, 15) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         resume          = ($urandom_range(0, 3) == 0);
         ex_memread      = $urandom_range(0, 1);
         ex_rd           = 5'($urandom_range(0, 3));
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 0;
            #2 rst_n = 1;
         end
         step();
      end

      // saturation: get back to RUN, then hold load-use
      idle(); resume = 1;
      step(); step(); step(); step(); step();
      idle();
      step();
      ex_memread = 1; ex_rd = 1; id_rs1 = 1;
      for (int i = 0; i < 65540; i++) step();
      check("sat", {16'd0, stall_cnt}, 32'h0000FFFF);
      idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_halt  input  1  Halt_Insert decoded for the instruction currently in IF/ID.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices of the instruction in IF/ID.
REQ-006 ex_memread  input  1  the instruction in ID/EX is a load.
REQ-007 ex_rd  input  5  destination index of the instruction in ID/EX.
REQ-008 ex_branch_taken  input  1  redirect (BR taken, JAL, JALR) resolved in EX this cycle.
REQ-009 resume  input  1  level request to leave HALTED.
REQ-010 pc_write  output  1  PC register load enable.
REQ-011 ifid_write  output  1  IF/ID register load enable.
REQ-012 ifid_flush  output  1  clear IF/ID to NOP.
REQ-013 idex_flush  output  1  insert a bubble into ID/EX (all control bits zero).
REQ-014 halted  output  1  core is halted; registered, equals (state==HALTED).
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-016 The block SHALL hold a registered state in {RUN, DRAIN, HALTED} plus a 2-bit drain counter; pc_write, ifid_write, ifid_flush and idex_flush SHALL be combinational from state and inputs.
REQ-017 load_use SHALL be defined as ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
REQ-018 RUN, no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
REQ-019 RUN, ex_branch_taken=1 (highest priority, overrides load_use and id_halt): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; state stays RUN.
REQ-020 RUN, load_use=1 and no branch: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1; stall_cnt increments by 1 (saturating at 16'hFFFF); state stays RUN.
REQ-021 RUN, id_halt=1, no branch, no load_use: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; next state DRAIN with drain counter loaded with 3.
REQ-022 RUN, id_halt=1 together with load_use: load_use SHALL win for that cycle; the halt is taken on the following cycle if still present.
REQ-023 DRAIN: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1; the counter decrements each cycle; when the counter equals 1, the next state SHALL be HALTED; exactly 3 DRAIN cycles.
REQ-024 DRAIN and HALTED SHALL ignore ex_branch_taken and load_use and SHALL NOT change stall_cnt.
REQ-025 HALTED, resume=0: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
REQ-026 HALTED, resume=1: pc_write=1, ifid_write=1 (overwrites the halt word with the next instruction), idex_flush=1, ifid_flush=0; next state RUN.
REQ-027 resume SHALL be ignored in RUN and DRAIN.
REQ-028 halted SHALL first assert on the 4th rising edge after the halt-detect cycle and SHALL deassert on the edge after a resume cycle.

Reset
REQ-029 rst_n=0 SHALL force, asynchronously, state=RUN, drain counter=0, stall_cnt=0, halted=0, in any state including mid-DRAIN.
REQ-030 With rst_n=0, combinational outputs SHALL read pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0 regardless of other inputs.
REQ-031 The first rising edge after rst_n rises SHALL be evaluated as a normal RUN cycle.

Verification
REQ-032 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1, stall_cnt 0->1; ex_rd=0 with the same inputs -> no stall.
REQ-033 Branch versus load_use: ex_branch_taken=1, load_use=1, id_halt=1 -> ifid_flush=1, idex_flush=1, pc_write=1, stall_cnt unchanged, state RUN.
REQ-034 Halt: id_halt=1 at cycle 0 -> 3 DRAIN cycles with idex_flush=1, halted=1 from cycle 4; branch pulse during DRAIN -> no change.
REQ-035 Resume: resume=1 in HALTED -> a single cycle with pc_write=1, ifid_write=1, idex_flush=1, then halted=0 and RUN outputs 1,1,0,0.
REQ-036 Saturation: 65540 consecutive load_use cycles -> stall_cnt holds 16'hFFFF.
REQ-037 Reset: rst_n pulsed low in the second DRAIN cycle -> halted=0, pc_write=1 immediately, stall_cnt=0.
